// File: rtl/bbox_pkg.sv
// bbox_pkg: shared types and helpers for the bitmap bounding-box aligner
//   state_t : scan FSM states
//   res_t   : registered result record (index fields sized for the widest supported bitmap)
//   idx_w   : bits needed to hold a count 0..n
package bbox_pkg;
  localparam int IW = 16;
  typedef enum logic [1:0] {IDLE, SCAN, CALC, DONE} state_t;
  typedef struct packed {
    logic [IW-1:0] lshift;
    logic [IW-1:0] dshift;
    logic [IW-1:0] tshift;
    logic          scale_h;
    logic          scale_v;
    logic          empty;
  } res_t;
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/bbox_prio_enc.sv
// bbox_prio_enc: lowest/highest set-bit index of a vector plus an any-bit flag
//   vec_i : input vector
//   lo_o  : index of the lowest set bit (0 when none)
//   hi_o  : index of the highest set bit (0 when none)
//   any_o : at least one bit set
module bbox_prio_enc
  import bbox_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int CW = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [CW-1:0]    lo_o,
  output logic [CW-1:0]    hi_o,
  output logic             any_o
);
  always_comb begin
    lo_o = '0;
    hi_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (vec_i[i]) lo_o = CW'(i);
    for (int i = 0; i < WIDTH; i++) if (vec_i[i]) hi_o = CW'(i);
  end
  assign any_o = |vec_i;
endmodule

// File: rtl/bitmap_bbox_aligner.sv
// bitmap_bbox_aligner: streams a WIDTH x HEIGHT bitmap row by row and reports its bounding-box alignment
//   start/busy                  : kick off a scan from IDLE / FSM not idle
//   row_valid/row_ready/row_data: row stream, top row first, bit 0 leftmost
//   res_valid/res_ready         : result handshake, outputs held while valid
//   lshift/dshift/tshift        : empty columns left, empty rows bottom/top
//   scale_h/scale_v/empty       : 2x scale hints, no pixel set
module bitmap_bbox_aligner
  import bbox_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int HEIGHT = 24,
  parameter int SCALE_H_THRESH = WIDTH / 2,
  parameter int SCALE_V_THRESH = HEIGHT / 2,
  localparam int CW = idx_w(WIDTH),
  localparam int RW = idx_w(HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             row_valid,
  input  logic [WIDTH-1:0] row_data,
  output logic             row_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CW-1:0]    lshift,
  output logic [RW-1:0]    dshift,
  output logic [RW-1:0]    tshift,
  output logic             scale_h,
  output logic             scale_v,
  output logic             empty,
  output logic             busy
);
  state_t           state_q, state_d;
  logic [RW-1:0]    row_cnt_q, first_q, last_q, dsh;
  logic [WIDTH-1:0] col_or_q;
  logic             seen_q, acc, last_row, any;
  logic [CW-1:0]    lo, hi;
  logic [CW:0]      empty_cols;
  logic [RW:0]      empty_rows;
  res_t             res_q, res_d;
  bbox_prio_enc #(.WIDTH(WIDTH)) u_enc (.vec_i(col_or_q), .lo_o(lo), .hi_o(hi), .any_o(any));
  assign acc      = row_valid & row_ready;
  assign last_row = row_cnt_q == RW'(HEIGHT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (start ? SCAN : IDLE) :
              state_q == SCAN ? (acc && last_row ? CALC : SCAN) :
              state_q == CALC ? DONE :
              (res_ready ? IDLE : DONE);
  always_comb begin
    row_ready = state_q == SCAN;
    res_valid = state_q == DONE;
    busy      = state_q != IDLE;
  end
  // any mirrors seen: the column OR is non-zero exactly when some row had a pixel
  always_comb begin
    dsh            = RW'(HEIGHT - 1) - last_q;
    empty_cols     = (CW+1)'(WIDTH) - ((CW+1)'(hi) - (CW+1)'(lo) + (CW+1)'(1));
    empty_rows     = (RW+1)'(first_q) + (RW+1)'(dsh);
    res_d.lshift   = any ? IW'(lo) : '0;
    res_d.tshift   = any ? IW'(first_q) : '0;
    res_d.dshift   = any ? IW'(dsh) : '0;
    res_d.scale_h  = any && empty_cols >= (CW+1)'(SCALE_H_THRESH);
    res_d.scale_v  = any && empty_rows >= (RW+1)'(SCALE_V_THRESH);
    res_d.empty    = !any;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_cnt_q <= '0;
      col_or_q  <= '0;
      first_q   <= '0;
      last_q    <= '0;
      seen_q    <= 1'b0;
      res_q     <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        row_cnt_q <= '0;
        col_or_q  <= '0;
        seen_q    <= 1'b0;
      end
      if (acc) begin
        col_or_q  <= col_or_q | row_data;
        row_cnt_q <= row_cnt_q + RW'(1);
        if (|row_data) begin
          if (!seen_q) first_q <= row_cnt_q;
          seen_q <= 1'b1;
          last_q <= row_cnt_q;
        end
      end
      if (state_q == CALC) res_q <= res_d;
    end
  assign lshift  = CW'(res_q.lshift);
  assign dshift  = RW'(res_q.dshift);
  assign tshift  = RW'(res_q.tshift);
  assign scale_h = res_q.scale_h;
  assign scale_v = res_q.scale_v;
  assign empty   = res_q.empty;
endmodule

// File: tb/tb_bitmap_bbox_aligner.sv
// tb_bitmap_bbox_aligner: scoreboard bench for the default 64x24 and an 8x4 instance
module tb_bitmap_bbox_aligner;
  typedef struct {int l, d, t, sh, sv, e;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic a_start = 0, a_rv = 0, a_rsr = 0;
  logic [63:0] a_rd = '0;
  logic a_rr, a_rsv, a_sh, a_sv, a_e, a_busy;
  logic [6:0] a_l;
  logic [4:0] a_d, a_t;
  logic b_start = 0, b_rv = 0, b_rsr = 0;
  logic [7:0] b_rd = '0;
  logic b_rr, b_rsv, b_sh, b_sv, b_e, b_busy;
  logic [3:0] b_l;
  logic [2:0] b_d, b_t;
  exp_t qa[$], qb[$];
  logic [63:0] bmp[24];
  int checks = 0, errors = 0;
  bitmap_bbox_aligner dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .row_valid(a_rv), .row_data(a_rd),
    .row_ready(a_rr), .res_valid(a_rsv), .res_ready(a_rsr), .lshift(a_l), .dshift(a_d),
    .tshift(a_t), .scale_h(a_sh), .scale_v(a_sv), .empty(a_e), .busy(a_busy));
  bitmap_bbox_aligner #(.WIDTH(8), .HEIGHT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .row_valid(b_rv), .row_data(b_rd),
    .row_ready(b_rr), .res_valid(b_rsv), .res_ready(b_rsr), .lshift(b_l), .dshift(b_d),
    .tshift(b_t), .scale_h(b_sh), .scale_v(b_sv), .empty(b_e), .busy(b_busy));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst_n && a_rsv && a_rsr) begin : mon_a
      exp_t e;
      if (qa.size() == 0) chk("a_unexpected_result", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_lshift", a_l, e.l);
        chk("a_dshift", a_d, e.d);
        chk("a_tshift", a_t, e.t);
        chk("a_scale_h", a_sh, e.sh);
        chk("a_scale_v", a_sv, e.sv);
        chk("a_empty", a_e, e.e);
      end
    end
  always @(negedge clk)
    if (rst_n && b_rsv && b_rsr) begin : mon_b
      exp_t e;
      if (qb.size() == 0) chk("b_unexpected_result", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_lshift", b_l, e.l);
        chk("b_dshift", b_d, e.d);
        chk("b_tshift", b_t, e.t);
        chk("b_scale_h", b_sh, e.sh);
        chk("b_scale_v", b_sv, e.sv);
        chk("b_empty", b_e, e.e);
      end
    end
  task automatic clear_bmp();
    for (int r = 0; r < 24; r++) bmp[r] = '0;
  endtask
  task automatic scan_a(input int gap, input int nrows);
    a_start = 1;
    step();
    a_start = 0;
    for (int r = 0; r < nrows; r++) begin
      if (gap != 0 && r > 0) begin
        a_rv = 0;
        step();
      end
      a_rv = 1;
      a_rd = bmp[r];
      step();
    end
    a_rv = 0;
  endtask
  task automatic wait_a();
    int n = 0;
    while (!a_rsv && n < 200) begin
      step();
      n++;
    end
    if (!a_rsv) chk("a_result_timeout", 0, 1);
  endtask
  task automatic release_a();
    a_rsr = 1;
    step();
    a_rsr = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    step();
    step();
    chk("reset_busy", a_busy, 0);
    chk("reset_res_valid", a_rsv, 0);
    chk("reset_row_ready", a_rr, 0);
    chk("reset_outputs", {a_l, a_d, a_t, a_sh, a_sv, a_e}, 0);
    rst_n = 1;
    step();
    // single pixel (5,10), latency observed with res_ready low
    clear_bmp();
    bmp[5] = 64'd1 << 10;
    qa.push_back('{10, 18, 5, 1, 1, 0});
    scan_a(0, 24);
    chk("t1_calc_res_valid", a_rsv, 0);
    chk("t1_calc_busy", a_busy, 1);
    step();
    chk("t1_done_res_valid", a_rsv, 1);
    release_a();
    chk("t1_idle_after", a_busy, 0);
    // full box, res_ready high in advance: DONE lasts one cycle
    for (int r = 0; r < 24; r++) bmp[r] = 64'hFFFF_FFFF_FFFF_FFFF;
    qa.push_back('{0, 0, 0, 0, 0, 0});
    a_rsr = 1;
    scan_a(0, 24);
    step();
    chk("t2_done_one_cycle", a_rsv, 1);
    step();
    chk("t2_valid_dropped", a_rsv, 0);
    a_rsr = 0;
    // all-zero bitmap
    clear_bmp();
    qa.push_back('{0, 0, 0, 0, 0, 1});
    scan_a(0, 24);
    wait_a();
    release_a();
    // two pixels, gapped rows, 5-cycle consumer stall, start at handshake ignored
    clear_bmp();
    bmp[2] = 64'd1;
    bmp[20] = 64'd1 << 40;
    qa.push_back('{0, 3, 2, 0, 0, 0});
    scan_a(1, 24);
    wait_a();
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_valid", a_rsv, 1);
      chk("t4_stall_fields", {a_l, a_d, a_t, a_sh, a_sv, a_e}, {7'd0, 5'd3, 5'd2, 3'b000});
      step();
    end
    a_rsr = 1;
    a_start = 1;
    step();
    a_rsr = 0;
    a_start = 0;
    chk("t4_start_at_handshake_busy", a_busy, 0);
    chk("t4_valid_dropped", a_rsv, 0);
    step();
    chk("t4_still_idle", a_busy, 0);
    // abort mid-scan with reset, then a clean scan
    for (int r = 0; r < 24; r++) bmp[r] = 64'hFFFF_FFFF_FFFF_FFFF;
    scan_a(0, 10);
    rst_n = 0;
    #1;
    chk("t5_reset_busy", a_busy, 0);
    chk("t5_reset_outputs", {a_rsv, a_l, a_d, a_t, a_sh, a_sv, a_e}, 0);
    step();
    rst_n = 1;
    step();
    clear_bmp();
    bmp[0] = 64'd1 << 63;
    qa.push_back('{63, 23, 0, 1, 1, 0});
    scan_a(0, 24);
    wait_a();
    release_a();
    step();
    chk("t5_busy_after", a_busy, 0);
    // 8x4 instance: row_valid in IDLE ignored, start during SCAN ignored
    b_rv = 1;
    b_rd = 8'hFF;
    step();
    chk("b_idle_row_ready", b_rr, 0);
    b_rv = 0;
    qb.push_back('{3, 1, 1, 1, 1, 0});
    b_start = 1;
    step();
    b_start = 0;
    for (int r = 0; r < 4; r++) begin
      b_rv = 1;
      b_rd = (r == 1 || r == 2) ? 8'h18 : 8'h00;
      b_start = (r == 2);
      step();
    end
    b_rv = 0;
    b_start = 0;
    begin
      int n = 0;
      while (!b_rsv && n < 50) begin
        step();
        n++;
      end
      chk("b_result_seen", b_rsv, 1);
    end
    b_rsr = 1;
    step();
    b_rsr = 0;
    step();
    chk("b_idle_after", b_busy, 0);
    step();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
